// File: rtl/serial_decoder_pkg.sv
// Shared types and elaboration helpers for the serial vector decoder.
package serial_decoder_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    function automatic int bytes_for_bits(input int bits);
        return (bits + 7) / 8;
    endfunction

    // $clog2 with a floor of 1 so single-entry indices still get a real wire.
    function automatic int index_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_timeout_counter.sv
// Counts idle cycles while enabled; pulses expire on the cycle the count would reach TIMEOUT_CYCLES.
module serial_timeout_counter
    import serial_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = clk ^ reset ^ clear ^ enable;
            assign expire = 1'b0;
        end else begin : g_enabled
            localparam int CW = index_bits(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count;

            // The count restarts whenever the idle run is broken or the counter is not armed.
            always_ff @(posedge clk) begin
                if (reset || clear || !enable) begin
                    count <= '0;
                end else if (count == LAST_COUNT) begin
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end

            assign expire = enable && !clear && (count == LAST_COUNT);
        end
    endgenerate

endmodule

// File: rtl/serial_vector_decoder.sv
// Reassembles LSB-first byte streams into signed numbers, presented on a valid/ready output.
// Handshake: a number transfers in any cycle where out_valid && out_ready; out_valid holds until then.
module serial_vector_decoder
    import serial_decoder_pkg::*;
#(
    parameter int NUMBER_BITS    = 37,
    parameter int NUMBER_BYTES   = 5,
    parameter int NUM_COUNT      = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       received_byte,
    input  logic                             received_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUMBER_BITS-1:0]           num,
    output logic [index_bits(NUM_COUNT)-1:0] num_index,
    output logic                             last,
    output logic                             range_error,
    output logic                             timeout,
    output logic                             overrun
);

    localparam int IDX_W   = index_bits(NUM_COUNT);
    localparam int BIDX_W  = index_bits(NUMBER_BYTES);
    localparam int STORE_W = NUMBER_BYTES * 8;
    localparam int PAD_W   = STORE_W - NUMBER_BITS;
    localparam logic [BIDX_W-1:0] LAST_SLOT  = BIDX_W'(NUMBER_BYTES - 1);
    localparam logic [IDX_W-1:0]  LAST_INDEX = IDX_W'(NUM_COUNT - 1);

    generate
        if (NUMBER_BYTES != bytes_for_bits(NUMBER_BITS)) begin : g_bad_bytes
            $error("NUMBER_BYTES must equal ceil(NUMBER_BITS/8)");
        end
    endgenerate

    state_t              state;
    state_t              state_next;
    logic [BIDX_W-1:0]   byte_index;
    logic [BIDX_W-1:0]   slot;
    logic [STORE_W-1:0]  store;
    logic                handshake;
    logic                byte_accept;
    logic                completes;
    logic                timer_enable;
    logic                expire;

    // A byte in HOLD is only taken when the held number leaves in the same cycle.
    always_comb begin
        handshake   = (state == HOLD) && out_ready;
        byte_accept = received_ready && ((state == COLLECT) || out_ready);
        slot        = (state == HOLD) ? '0 : byte_index;
        completes   = byte_accept && (slot == LAST_SLOT);
        state_next  = state;
        if (completes) begin
            state_next = HOLD;
        end else if (handshake) begin
            state_next = COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    assign timer_enable = (state == COLLECT) && (byte_index != '0);

    serial_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (byte_accept),
        .enable (timer_enable),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_index <= '0;
            num_index  <= '0;
            store      <= '0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            timeout <= expire;
            if (byte_accept) begin
                for (int i = 0; i < NUMBER_BYTES; i++) begin
                    if (slot == BIDX_W'(i)) begin
                        store[i*8 +: 8] <= received_byte;
                    end
                end
                byte_index <= completes ? '0 : slot + 1'b1;
            end else if (expire) begin
                byte_index <= '0;
            end
            // A timeout resynchronises to the start of the vector.
            if (handshake) begin
                num_index <= (num_index == LAST_INDEX) ? '0 : num_index + 1'b1;
            end else if (expire) begin
                num_index <= '0;
            end
            if (received_ready && (state == HOLD) && !out_ready) begin
                overrun <= 1'b1;
            end
        end
    end

    assign out_valid = (state == HOLD);
    assign last      = (num_index == LAST_INDEX);
    assign num       = store[NUMBER_BITS-1:0];

    generate
        if (PAD_W > 0) begin : g_range
            assign range_error = (store[STORE_W-1:NUMBER_BITS] != {PAD_W{store[NUMBER_BITS-1]}});
        end else begin : g_no_range
            assign range_error = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_serial_vector_decoder.sv
// Directed bench for serial_vector_decoder with a shortened inter-byte timeout.
module tb_serial_vector_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  received_byte;
    logic        received_ready;
    logic        out_valid;
    logic        out_ready;
    logic [36:0] num;
    logic [1:0]  num_index;
    logic        last;
    logic        range_error;
    logic        timeout;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_vector_decoder #(
        .NUMBER_BITS    (37),
        .NUMBER_BYTES   (5),
        .NUM_COUNT      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .received_byte  (received_byte),
        .received_ready (received_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .num            (num),
        .num_index      (num_index),
        .last           (last),
        .range_error    (range_error),
        .timeout        (timeout),
        .overrun        (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        received_byte  = b;
        received_ready = 1'b1;
        tick();
        received_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end n_vec++;
        if (num !== 37'h0) begin n_err++; $display("FAIL reset_num: got %h want 0", num); end n_vec++;
        if (num_index !== 2'd0) begin n_err++; $display("FAIL reset_index: got %0d want 0", num_index); end n_vec++;
        if (range_error !== 1'b0) begin n_err++; $display("FAIL reset_range: got %0b want 0", range_error); end n_vec++;
        if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %0b want 0", timeout); end n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %0b want 0", overrun); end n_vec++;
        if (last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %0b want 0", last); end n_vec++;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_partial_valid: got %0b want 0", out_valid); end n_vec++;
        send_byte(8'h00);
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b want 1", out_valid); end n_vec++;
        if (num !== 37'h00_0403_0201) begin n_err++; $display("FAIL basic_num: got %h want 0004030201", num); end n_vec++;
        if (num_index !== 2'd0) begin n_err++; $display("FAIL basic_index: got %0d want 0", num_index); end n_vec++;
        if (range_error !== 1'b0) begin n_err++; $display("FAIL basic_range: got %0b want 0", range_error); end n_vec++;
        tick();
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_after_hs_valid: got %0b want 0", out_valid); end n_vec++;
        if (num_index !== 2'd1) begin n_err++; $display("FAIL basic_after_hs_index: got %0d want 1", num_index); end n_vec++;
    endtask

    task automatic test_sign();
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) send_byte(8'hFF);
        if (num !== 37'h1F_FFFF_FFFF) begin n_err++; $display("FAIL sign_neg_num: got %h want 1fffffffff", num); end n_vec++;
        if (range_error !== 1'b0) begin n_err++; $display("FAIL sign_neg_range: got %0b want 0", range_error); end n_vec++;
        if (num_index !== 2'd1) begin n_err++; $display("FAIL sign_neg_index: got %0d want 1", num_index); end n_vec++;
        tick();
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h1F);
        if (num !== 37'h1F_0000_0010) begin n_err++; $display("FAIL sign_bad_num: got %h want 1f00000010", num); end n_vec++;
        if (range_error !== 1'b1) begin n_err++; $display("FAIL sign_bad_range: got %0b want 1", range_error); end n_vec++;
        if (num_index !== 2'd2) begin n_err++; $display("FAIL sign_bad_index: got %0d want 2", num_index); end n_vec++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [39:0] vec_bytes [5];
        logic [36:0] exp_num   [5];
        logic [1:0]  exp_idx   [5];
        logic        exp_last  [5];
        vec_bytes = '{40'h05_4433_2211, 40'h0E_D0C0_B0A0, 40'h00_0000_0001, 40'hF0_0000_0000, 40'hFF_FFFF_FFFE};
        exp_num   = '{37'h05_4433_2211, 37'h0E_D0C0_B0A0, 37'h00_0000_0001, 37'h10_0000_0000, 37'h1F_FFFF_FFFE};
        exp_idx   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_last  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            for (int j = 0; j < 5; j++) begin
                send_byte(vec_bytes[n][j*8 +: 8]);
                if (j == 0 && n > 0) begin
                    if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap_valid[%0d]: got %0b want 0", n, out_valid); end n_vec++;
                end
            end
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %0b want 1", n, out_valid); end n_vec++;
            if (num !== exp_num[n]) begin n_err++; $display("FAIL b2b_num[%0d]: got %h want %h", n, num, exp_num[n]); end n_vec++;
            if (num_index !== exp_idx[n]) begin n_err++; $display("FAIL b2b_index[%0d]: got %0d want %0d", n, num_index, exp_idx[n]); end n_vec++;
            if (last !== exp_last[n]) begin n_err++; $display("FAIL b2b_last[%0d]: got %0b want %0b", n, last, exp_last[n]); end n_vec++;
            if (range_error !== 1'b0) begin n_err++; $display("FAIL b2b_range[%0d]: got %0b want 0", n, range_error); end n_vec++;
        end
        tick();
    endtask

    task automatic test_overrun();
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        if (num !== 37'h05_0403_0201) begin n_err++; $display("FAIL ovr_num: got %h want 0504030201", num); end n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %0b want 0", overrun); end n_vec++;
        send_byte(8'hAA);
        if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0b want 1", overrun); end n_vec++;
        if (num !== 37'h05_0403_0201) begin n_err++; $display("FAIL ovr_frozen_num: got %h want 0504030201", num); end n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_hold_valid: got %0b want 1", out_valid); end n_vec++;
        tick();
        if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end n_vec++;
        out_ready = 1'b1;
        send_byte(8'h77);
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_hs_valid: got %0b want 0", out_valid); end n_vec++;
        if (num_index !== 2'd1) begin n_err++; $display("FAIL ovr_hs_index: got %0d want 1", num_index); end n_vec++;
        send_byte(8'h66); send_byte(8'h55); send_byte(8'h44); send_byte(8'h03);
        if (num !== 37'h03_4455_6677) begin n_err++; $display("FAIL ovr_next_num: got %h want 0344556677", num); end n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_next_valid: got %0b want 1", out_valid); end n_vec++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_still_set: got %0b want 1", overrun); end n_vec++;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        out_ready = 1'b1;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        tick();
        send_byte(8'hC1); send_byte(8'hC2);
        for (int i = 0; i < 8; i++) begin
            if (timeout !== 1'b0) begin n_err++; $display("FAIL to_early[%0d]: got %0b want 0", i, timeout); end n_vec++;
            tick();
        end
        if (timeout !== 1'b1) begin n_err++; $display("FAIL to_pulse: got %0b want 1", timeout); end n_vec++;
        if (num_index !== 2'd0) begin n_err++; $display("FAIL to_index_resync: got %0d want 0", num_index); end n_vec++;
        tick();
        if (timeout !== 1'b0) begin n_err++; $display("FAIL to_pulse_end: got %0b want 0", timeout); end n_vec++;
        send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24); send_byte(8'h02);
        if (num !== 37'h02_2423_2221) begin n_err++; $display("FAIL to_fresh_num: got %h want 0224232221", num); end n_vec++;
        if (num_index !== 2'd0) begin n_err++; $display("FAIL to_fresh_index: got %0d want 0", num_index); end n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL to_fresh_valid: got %0b want 1", out_valid); end n_vec++;
        tick();
        send_byte(8'h31); send_byte(8'h32);
        for (int i = 0; i < 7; i++) begin
            if (timeout !== 1'b0) begin n_err++; $display("FAIL race_early[%0d]: got %0b want 0", i, timeout); end n_vec++;
            tick();
        end
        send_byte(8'h33);
        if (timeout !== 1'b0) begin n_err++; $display("FAIL race_no_pulse: got %0b want 0", timeout); end n_vec++;
        if (num_index !== 2'd1) begin n_err++; $display("FAIL race_index: got %0d want 1", num_index); end n_vec++;
        tick();
        if (timeout !== 1'b0) begin n_err++; $display("FAIL race_no_pulse2: got %0b want 0", timeout); end n_vec++;
        send_byte(8'h34); send_byte(8'h03);
        if (num !== 37'h03_3433_3231) begin n_err++; $display("FAIL race_num: got %h want 0334333231", num); end n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL race_valid: got %0b want 1", out_valid); end n_vec++;
        tick();
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h88); send_byte(8'h77); send_byte(8'h66); send_byte(8'h55); send_byte(8'hE4);
        if (num !== 37'h04_5566_7788) begin n_err++; $display("FAIL rh_num: got %h want 0455667788", num); end n_vec++;
        if (range_error !== 1'b1) begin n_err++; $display("FAIL rh_range: got %0b want 1", range_error); end n_vec++;
        send_byte(8'h99);
        if (overrun !== 1'b1) begin n_err++; $display("FAIL rh_overrun_set: got %0b want 1", overrun); end n_vec++;
        do_reset();
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rh_valid: got %0b want 0", out_valid); end n_vec++;
        if (num !== 37'h0) begin n_err++; $display("FAIL rh_num_clear: got %h want 0", num); end n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL rh_overrun_clear: got %0b want 0", overrun); end n_vec++;
        if (range_error !== 1'b0) begin n_err++; $display("FAIL rh_range_clear: got %0b want 0", range_error); end n_vec++;
        if (num_index !== 2'd0) begin n_err++; $display("FAIL rh_index: got %0d want 0", num_index); end n_vec++;
    endtask

    initial begin
        reset          = 1'b0;
        received_byte  = 8'h00;
        received_ready = 1'b0;
        out_ready      = 1'b0;
        test_reset();
        test_basic();
        test_sign();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
